// File: rtl/pkt_ingress_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-stream sources into one stream.
// Grant is held from first beat to tlast; per-packet metadata pulse and per-port counters.

module pkt_ingress_pkt_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module pkt_ingress_rr_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int METADATA_WIDTH  = 263,
  localparam int GW             = $clog2(NUM_PORTS)
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_rst,
  input  logic [NUM_PORTS-1:0]                 port_enable,
  input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
  output logic [NUM_PORTS-1:0]                 s_axis_tready,
  input  logic [NUM_PORTS*METADATA_WIDTH-1:0]  s_metadata,
  output logic                                 m_axis_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [METADATA_WIDTH-1:0]            user_metadata_out,
  output logic                                 user_metadata_out_valid,
  output logic [GW-1:0]                        grant_port,
  output logic [NUM_PORTS*32-1:0]              pkt_count
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  first_q, first_d;

  logic                       sel_tvalid, sel_tlast;
  logic [AXIS_DATA_WIDTH-1:0] sel_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] sel_tkeep;
  logic [METADATA_WIDTH-1:0]  sel_meta;
  logic [NUM_PORTS-1:0]       cand, inc;
  logic                       busy, hs;

  always_comb begin
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_meta   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
        sel_tdata  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_tkeep  = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        sel_meta   = s_metadata[i*METADATA_WIDTH +: METADATA_WIDTH];
      end
    end
  end

  // Gating with reset keeps a stale BUSY state from forwarding a beat in the reset cycle.
  assign busy                    = (state_q == BUSY) && !axis_rst;
  assign m_axis_tvalid           = busy && sel_tvalid;
  assign m_axis_tdata            = sel_tdata;
  assign m_axis_tkeep            = sel_tkeep;
  assign m_axis_tlast            = sel_tlast;
  assign user_metadata_out       = sel_meta;
  assign hs                      = m_axis_tvalid && m_axis_tready;
  assign user_metadata_out_valid = hs && first_q;
  assign grant_port              = grant_q;
  assign cand                    = s_axis_tvalid & port_enable;

  always_comb begin
    s_axis_tready = '0;
    inc           = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_axis_tready[i] = busy && m_axis_tready && (grant_q == GW'(i));
      inc[i]           = hs && sel_tlast && (grant_q == GW'(i));
    end
  end

  // Pick the candidate nearest above the pointer: distance 0 means grant_q+1.
  always_comb begin
    int best;
    int d;
    state_d = state_q;
    grant_d = grant_q;
    first_d = first_q;
    best    = NUM_PORTS;
    d       = 0;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          d = i - int'(grant_q) - 1;
          if (d < 0) d = d + NUM_PORTS;
          if (cand[i] && d < best) begin
            best    = d;
            grant_d = GW'(i);
          end
        end
        if (best < NUM_PORTS) begin
          state_d = BUSY;
          first_d = 1'b1;
        end
      end
      BUSY: begin
        if (hs) begin
          first_d = 1'b0;
          if (sel_tlast) begin
            first_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_PORTS-1);
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      first_q <= first_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    pkt_ingress_pkt_cnt u_cnt (
      .clk (axis_aclk),
      .rst (axis_rst),
      .inc (inc[g]),
      .cnt (pkt_count[g*32 +: 32])
    );
  end
endmodule

// File: tb/tb_pkt_ingress_rr_arbiter.sv
// Directed + randomized bench for pkt_ingress_rr_arbiter against a packet-level round-robin model.

module tb_pkt_ingress_rr_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    port_enable = '1;
  logic [NP-1:0]    s_tvalid = '0, s_tlast = '0, s_tready;
  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP*KW-1:0] s_tkeep = '0;
  logic [NP*MW-1:0] s_meta = '0;
  logic             m_tvalid, m_tlast, m_tready = 1'b0;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [MW-1:0]    umeta;
  logic             umv;
  logic [1:0]       grant;
  logic [NP*32-1:0] pkt_count;

  pkt_ingress_rr_arbiter #(
    .NUM_PORTS(NP), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .METADATA_WIDTH(MW)
  ) dut (
    .axis_aclk(clk), .axis_rst(rst), .port_enable(port_enable),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .s_metadata(s_meta),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .user_metadata_out(umeta), .user_metadata_out_valid(umv),
    .grant_port(grant), .pkt_count(pkt_count)
  );

  int vectors = 0, errs = 0;

  // Reference: round-robin pointer, current packet owner, per-port packet lists.
  bit          m_busy = 0, m_first = 1;
  int          m_cur = 0, m_ptr = NP-1;
  int unsigned m_cnt[NP];
  int          s_pk[NP], s_beat[NP], s_len[NP], quota[NP];
  int          vprob = 100, rprob = 100, fix_len = 1;
  bit          rdy_q[$];
  int          glog[$];
  int          mv_cyc[$];
  int          cyc = 0, p0_bad = 0;
  int          rdy_hits[NP];
  bit          sv_rst, sv_hs;
  logic [NP-1:0] sv_v, sv_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int newlen();
    return (fix_len != 0) ? fix_len : int'($urandom_range(5, 1));
  endfunction

  function automatic logic [DW-1:0] enc(int p, int k, int b, int l);
    return {8'(p), 8'(k), 8'(b), 8'(l)};
  endfunction

  function automatic bit done();
    for (int i = 0; i < NP; i++)
      if (quota[i] < 1000 && s_pk[i] < quota[i]) return 1'b0;
    return !m_busy;
  endfunction

  task automatic reset_model();
    m_busy = 0; m_first = 1; m_cur = 0; m_ptr = NP-1;
    for (int i = 0; i < NP; i++) begin
      m_cnt[i] = 0; s_pk[i] = 0; s_beat[i] = 0; quota[i] = 0; s_len[i] = newlen();
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      s_tvalid[i]          = (s_pk[i] < quota[i]) && (int'($urandom_range(99, 0)) < vprob);
      s_tdata[i*DW +: DW]  = enc(i, s_pk[i], s_beat[i], s_len[i]);
      s_tkeep[i*KW +: KW]  = 4'(s_beat[i] + 1);
      s_tlast[i]           = (s_beat[i] == s_len[i] - 1);
      s_meta[i*MW +: MW]   = {8'(i), 8'(s_pk[i])};
    end
    if (rdy_q.size() > 0) m_tready = rdy_q.pop_front();
    else                  m_tready = (int'($urandom_range(99, 0)) < rprob);
  endtask

  task automatic check();
    bit ev, emv;
    logic [NP-1:0] er;
    ev  = !rst && m_busy && s_tvalid[m_cur];
    er  = (!rst && m_busy && m_tready) ? (4'b0001 << m_cur) : 4'b0000;
    emv = ev && m_tready && m_first;
    chk("m_tvalid", m_tvalid, ev);
    chk("s_tready", s_tready, er);
    chk("meta_valid", umv, emv);
    chk("grant_port", grant, m_ptr);
    for (int i = 0; i < NP; i++) chk("pkt_count", pkt_count[i*32 +: 32], m_cnt[i]);
    if (ev) begin
      chk("m_tdata", m_tdata, enc(m_cur, s_pk[m_cur], s_beat[m_cur], s_len[m_cur]));
      chk("m_tlast", m_tlast, s_beat[m_cur] == s_len[m_cur] - 1);
      chk("m_tkeep", m_tkeep, 4'(s_beat[m_cur] + 1));
    end
    if (emv) begin
      chk("metadata", umeta, {8'(m_cur), 8'(s_pk[m_cur])});
      mv_cyc.push_back(cyc);
    end
    for (int i = 0; i < NP; i++) if (s_tready[i]) rdy_hits[i]++;
    if (m_busy && m_cur == 1 && s_tready[0]) p0_bad++;
    sv_rst = rst; sv_v = s_tvalid; sv_en = port_enable; sv_hs = ev && m_tready;
  endtask

  task automatic update();
    if (sv_rst) reset_model();
    else if (!m_busy) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (sv_v[p] && sv_en[p]) begin
          m_busy = 1; m_cur = p; m_ptr = p; m_first = 1;
          glog.push_back(p);
          break;
        end
      end
    end else if (sv_hs) begin
      m_first = 0;
      if (s_beat[m_cur] == s_len[m_cur] - 1) begin
        m_cnt[m_cur]++;
        m_busy = 0; m_first = 1;
        s_pk[m_cur]++; s_beat[m_cur] = 0; s_len[m_cur] = newlen();
      end else s_beat[m_cur]++;
    end
    cyc++;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_until(input int budget, input string tag);
    int n;
    n = 0;
    while (!done() && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, done(), 1'b1);
  endtask

  initial begin
    int c0;
    int e2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int e4[4] = '{0, 1, 3, 0};

    repeat (2) @(posedge clk);
    #1;
    reset_model();
    rst = 1'b0;

    // 3-beat packet from port 2 alone
    fix_len = 3; do_reset();
    glog.delete(); mv_cyc.delete();
    c0 = cyc; quota[2] = 1;
    run_until(50, "seg1_timeout");
    chk("seg1_pulses", mv_cyc.size(), 1);
    chk("seg1_latency", mv_cyc[0] - c0, 1);
    chk("seg1_cnt2", pkt_count[95:64], 1);
    chk("seg1_grant", grant, 2);

    // all ports valid, 2-beat packets, 8 packets
    fix_len = 2; do_reset();
    glog.delete();
    for (int i = 0; i < NP; i++) quota[i] = 2;
    run_until(100, "seg2_timeout");
    chk("seg2_ngrants", glog.size(), 8);
    for (int k = 0; k < 8; k++) chk("seg2_order", glog[k], e2[k]);
    for (int i = 0; i < NP; i++) chk("seg2_cnt", pkt_count[i*32 +: 32], 2);

    // backpressure on port 1 while port 0 waits
    fix_len = 2; do_reset();
    glog.delete(); p0_bad = 0;
    quota[1] = 1;
    cycle();
    quota[0] = 1;
    rdy_q.push_back(1); rdy_q.push_back(0); rdy_q.push_back(0); rdy_q.push_back(1);
    run_until(50, "seg3_timeout");
    chk("seg3_ngrants", glog.size(), 2);
    chk("seg3_first", glog[0], 1);
    chk("seg3_next", glog[1], 0);
    chk("seg3_p0_ready_leak", p0_bad, 0);

    // port 2 disabled but valid
    fix_len = 2; do_reset();
    glog.delete();
    for (int i = 0; i < NP; i++) rdy_hits[i] = 0;
    port_enable = 4'b1011;
    quota[0] = 2; quota[1] = 1; quota[2] = 1000; quota[3] = 1;
    run_until(200, "seg4_timeout");
    repeat (3) cycle();
    chk("seg4_ngrants", glog.size(), 4);
    for (int k = 0; k < 4; k++) chk("seg4_order", glog[k], e4[k]);
    chk("seg4_p2_ready", rdy_hits[2], 0);
    quota[2] = 0; port_enable = 4'b1111;

    // reset in the middle of beat 2 of a 4-beat packet
    fix_len = 4; do_reset();
    quota[0] = 2;
    begin
      int n;
      n = 0;
      while (!(s_pk[0] == 1 && m_busy && s_beat[0] == 1) && n < 40) begin
        cycle();
        n++;
      end
      chk("seg5_reach_beat2", n < 40, 1'b1);
    end
    chk("seg5_cnt_before", pkt_count[31:0], 1);
    do_reset();
    chk("seg5_vld_after", m_tvalid, 1'b0);
    chk("seg5_cnt_after", pkt_count, '0);
    glog.delete();
    quota[0] = 1; quota[1] = 1;
    run_until(50, "seg5_timeout");
    chk("seg5_first_grant", glog[0], 0);

    // five single-beat packets on port 3
    fix_len = 1; do_reset();
    mv_cyc.delete();
    quota[3] = 5;
    run_until(50, "seg6_timeout");
    chk("seg6_pulses", mv_cyc.size(), 5);
    for (int k = 1; k < 5; k++) chk("seg6_spacing", mv_cyc[k] - mv_cyc[k-1], 2);
    chk("seg6_cnt3", pkt_count[127:96], 5);

    // randomized traffic, backpressure, and enables
    fix_len = 0; do_reset();
    vprob = 60; rprob = 70;
    for (int i = 0; i < NP; i++) quota[i] = 8;
    begin
      int n;
      n = 0;
      while (!done() && n < 4000) begin
        if (n % 64 == 0) port_enable = 4'($urandom_range(15, 0));
        cycle();
        n++;
      end
    end
    port_enable = 4'b1111;
    run_until(2000, "seg7_timeout");
    for (int i = 0; i < NP; i++) chk("seg7_cnt", pkt_count[i*32 +: 32], 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/pkt_ingress_rr_arbiter.md
Name: pkt_ingress_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_PORTS AXI-stream packet sources into the single stream consumed by packet_classification.
- Grant is held from first beat to tlast, so packets are never interleaved.
- Emits a per-packet metadata pulse (source port, metadata word) and a per-port packet counter for debug.
- Sits directly upstream of the classifier s_axis/user_metadata_in inputs.

Parameters:
NUM_PORTS, 4, number of input streams (2..8)
AXIS_DATA_WIDTH, 512, tdata width
AXIS_KEEP_WIDTH, 64, tkeep width
METADATA_WIDTH, 263, per-packet metadata width

Ports:
axis_aclk  in  1  clock
axis_rst  in  1  synchronous active-high reset
port_enable  in  NUM_PORTS  per-port arbitration enable
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tdata  in  NUM_PORTS*AXIS_DATA_WIDTH  per-port data, port i at [i*W +: W]
s_axis_tkeep  in  NUM_PORTS*AXIS_KEEP_WIDTH  per-port keep
s_axis_tlast  in  NUM_PORTS  per-port last
s_axis_tready  out  NUM_PORTS  per-port ready
s_metadata  in  NUM_PORTS*METADATA_WIDTH  per-port metadata, stable from first beat to tlast
m_axis_tvalid  out  1  merged valid
m_axis_tdata  out  AXIS_DATA_WIDTH  merged data
m_axis_tkeep  out  AXIS_KEEP_WIDTH  merged keep
m_axis_tlast  out  1  merged last
m_axis_tready  in  1  merged ready
user_metadata_out  out  METADATA_WIDTH  metadata of the current packet
user_metadata_out_valid  out  1  one-cycle pulse on the first-beat handshake
grant_port  out  $clog2(NUM_PORTS)  currently or last granted port
pkt_count  out  NUM_PORTS*32  completed packets per port, wrapping

Behaviour:
- Reset (axis_rst=1 at a clock edge) forces the following; any in-flight packet is abandoned and no beat is forwarded during reset:
  - state=IDLE, grant_port=NUM_PORTS-1, so port 0 wins first.
  - All s_axis_tready=0, m_axis_tvalid=0, user_metadata_out_valid=0.
  - pkt_count=0, first_beat flag=1.
- FSM states: IDLE, BUSY.
- IDLE:
  - m_axis_tvalid=0 and all tready=0.
  - Candidates are ports with s_axis_tvalid[i] & port_enable[i].
  - If any candidate exists, select the first candidate searching upward from (grant_port+1) mod NUM_PORTS, wrapping. Register it into grant_port, set first_beat=1, go to BUSY.
  - If there are no candidates, stay in IDLE.
- BUSY (port g = grant_port):
  - Combinational pass-through:
    - m_axis_tvalid = s_axis_tvalid[g].
    - m_axis_tdata/tkeep/tlast come from port g.
    - s_axis_tready[g] = m_axis_tready; all other tready = 0.
    - user_metadata_out = s_metadata[g].
  - user_metadata_out_valid = m_axis_tvalid & m_axis_tready & first_beat (combinational). first_beat clears on that handshake.
  - On a handshake with tlast=1:
    - pkt_count[g] += 1 (32-bit wrap 0xFFFFFFFF→0).
    - first_beat returns to 1 and state goes to IDLE.
  - Port g deasserting tvalid mid-packet keeps the grant (no timeout).
  - port_enable[g] falling mid-packet has no effect until tlast.
- Latency:
  - Data path has 0 cycles in BUSY.
  - One bubble cycle (IDLE) between packets; back-to-back throughput is at most N beats per N+1 cycles for N-beat packets.
- A single-beat packet (tlast on the first beat) gives a metadata pulse and a count increment in the same cycle.
- With all ports enabled and continuously valid, the grant order is 0,1,2,3,0,... No port waits more than NUM_PORTS-1 packets.
- A port that is not enabled is never granted, even if it is valid.
- grant_port holds its value in IDLE; it is the round-robin pointer.

Test Plan:
- Reset, then port 2 only sends a 3-beat packet (tdata=0xA0,0xA1,0xA2) with m_axis_tready=1:
  - m_axis carries the 3 beats on consecutive cycles, starting 1 cycle after tvalid.
  - user_metadata_out_valid pulses once, with port 2 metadata.
  - pkt_count[2]=1, grant_port=2.
- All 4 ports continuously valid with 2-beat packets, 8 packets total:
  - grant order is 0,1,2,3,0,1,2,3.
  - No interleaving.
  - pkt_count = {2,2,2,2}.
- Port 1 granted; m_axis_tready toggles 1,0,0,1 while port 0 is also valid:
  - port 1's packet completes intact and s_axis_tready[0] stays 0 throughout.
  - Port 0 is granted next.
- port_enable=4'b1011 with all ports valid:
  - port 2 is never granted and s_axis_tready[2] stays 0.
  - Order is 0,1,3,0.
- axis_rst asserted during beat 2 of a 4-beat packet:
  - the next cycle shows m_axis_tvalid=0 and pkt_count=0.
  - After release, port 0 is granted first.
- Single-beat packets on port 3 only, 5 in a row:
  - 5 metadata pulses, one every 2 cycles.
  - pkt_count[3]=5.
